// File: rtl/rx_det_arbiter.sv
// Round-robin arbiter that lets NUM_LANES lanes share one receiver-detect circuit.
// Optional abort on a missing det_ack is enabled by defining RX_DET_ARB_TIMEOUT_EN.
module rx_det_arbiter #(
  parameter int NUM_LANES      = 4,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int GAP_CYCLES     = 2,
  parameter int CNT_W          = 11
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_LANES-1:0] lane_req,
  output logic [NUM_LANES-1:0] lane_ack,
  output logic [NUM_LANES-1:0] lane_det,
  output logic                 det_req,
  input  logic                 det_ack,
  input  logic                 det_vld,
  output logic [1:0]           grant_id,
  output logic                 busy,
  output logic                 timeout,
  output logic [2:0]           state_dbg
);

  // Handshake: lane_req is a level held until its lane_ack pulse; det_req is a
  // level held through WAIT and is answered by a single-cycle det_ack pulse.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_RESP  = 3'd3,
    S_GAP   = 3'd4
  } state_t;

  state_t           state;
  logic [1:0]       rr;
  logic [CNT_W-1:0] cnt;
  logic             req_lost;
  logic             pick_vld;
  logic [1:0]       pick;
  logic             held;

  assign state_dbg = state;

  // First requesting lane at or after the round-robin pointer, wrapping.
  always_comb begin
    int sum;
    pick_vld = 1'b0;
    pick     = rr;
    sum      = 0;
    for (int i = 0; i < NUM_LANES; i++) begin
      sum = int'(rr) + i;
      if (sum >= NUM_LANES) sum = sum - NUM_LANES;
      if (!pick_vld && lane_req[sum]) begin
        pick_vld = 1'b1;
        pick     = 2'(sum);
      end
    end
  end

  // A requester that let go at any point during WAIT gets no ack and no result.
  assign held = lane_req[grant_id] && !req_lost;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= S_IDLE;
      rr       <= 2'd0;
      cnt      <= '0;
      req_lost <= 1'b0;
      grant_id <= 2'd0;
      lane_ack <= '0;
      lane_det <= '0;
      det_req  <= 1'b0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      lane_ack <= '0;
      timeout  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (pick_vld) begin
            grant_id <= pick;
            busy     <= 1'b1;
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          det_req  <= 1'b1;
          cnt      <= '0;
          req_lost <= 1'b0;
          state    <= S_WAIT;
        end
        S_WAIT: begin
          if (!lane_req[grant_id]) req_lost <= 1'b1;
          if (det_ack) begin
            det_req <= 1'b0;
            state   <= S_RESP;
            if (held) begin
              lane_ack[grant_id] <= 1'b1;
              lane_det[grant_id] <= det_vld;
            end
          end
`ifdef RX_DET_ARB_TIMEOUT_EN
          else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            det_req <= 1'b0;
            timeout <= 1'b1;
            state   <= S_RESP;
            if (held) begin
              lane_ack[grant_id] <= 1'b1;
              lane_det[grant_id] <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
`else
          ;
`endif
        end
        S_RESP: begin
          busy  <= 1'b0;
          cnt   <= '0;
          rr    <= (grant_id == 2'(NUM_LANES - 1)) ? 2'd0 : grant_id + 2'd1;
          state <= (GAP_CYCLES > 0) ? S_GAP : S_IDLE;
        end
        S_GAP: begin
          if (cnt == CNT_W'(GAP_CYCLES - 1)) state <= S_IDLE;
          else cnt <= cnt + 1'b1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rx_det_arbiter.sv
// Directed bench for rx_det_arbiter: reset, round-robin order, long waits, dropped
// requests, the optional timeout (RX_DET_ARB_TIMEOUT_EN) and mid-transaction reset.
module tb_rx_det_arbiter;

  localparam int TB_TIMEOUT = 16;
`ifdef RX_DET_ARB_TIMEOUT_EN
  localparam int T1_HOLD = 12;
`else
  localparam int T1_HOLD = 499;
`endif

  logic       clk;
  logic       rst;
  logic [3:0] lane_req;
  logic [3:0] lane_ack;
  logic [3:0] lane_det;
  logic       det_req;
  logic       det_ack;
  logic       det_vld;
  logic [1:0] grant_id;
  logic       busy;
  logic       timeout;
  logic [2:0] state_dbg;

  int n_asserts = 0;
  int n_fail    = 0;
  int n;
  int k;

  rx_det_arbiter #(
    .NUM_LANES(4), .TIMEOUT_CYCLES(TB_TIMEOUT), .GAP_CYCLES(2), .CNT_W(11)
  ) dut (
    .clk(clk), .rst(rst), .lane_req(lane_req), .lane_ack(lane_ack),
    .lane_det(lane_det), .det_req(det_req), .det_ack(det_ack), .det_vld(det_vld),
    .grant_id(grant_id), .busy(busy), .timeout(timeout), .state_dbg(state_dbg)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Driver: serve one grant. Waits for det_req, holds for 'hold' cycles (optionally
  // dropping the request), pulses det_ack and checks the response and gap entry.
  task automatic do_txn(input int gid, input logic vld, input int hold,
                        input logic exp_ack, input int drop_at, output int waited);
    logic       hi_ok;
    logic [3:0] exp_vec;
    waited = 0;
    while (det_req !== 1'b1 && waited < 64) begin
      tick();
      waited++;
    end
    chk("det_req_rise", det_req, 1);
    chk("grant_id", grant_id, gid);
    chk("busy_wait", busy, 1);
    hi_ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      if (i == drop_at) lane_req[gid] = 1'b0;
      tick();
      if (det_req !== 1'b1) hi_ok = 1'b0;
    end
    chk("det_req_held", hi_ok, 1);
    det_ack = 1'b1;
    det_vld = vld;
    tick();
    det_ack = 1'b0;
    det_vld = 1'b0;
    exp_vec = exp_ack ? (4'b0001 << gid) : 4'b0000;
    chk("lane_ack", lane_ack, exp_vec);
    chk("det_req_resp", det_req, 0);
    chk("busy_resp", busy, 1);
    chk("timeout_resp", timeout, 0);
    tick();
    chk("lane_ack_pulse", lane_ack, 0);
    chk("busy_gap", busy, 0);
  endtask

  initial begin
    rst      = 1'b0;
    lane_req = 4'b0000;
    det_ack  = 1'b0;
    det_vld  = 1'b0;
    repeat (3) tick();
    chk("rst_lane_ack", lane_ack, 0);
    chk("rst_lane_det", lane_det, 0);
    chk("rst_det_req", det_req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_grant_id", grant_id, 0);

    // T2: all lanes held, granted 0,1,2,3 with the gap between each
    rst      = 1'b1;
    lane_req = 4'b1111;
    do_txn(0, 1'b1, 3, 1'b1, -1, n);
    chk("t2_latency", n, 2);
    do_txn(1, 1'b1, 3, 1'b1, -1, n);
    chk("t2_gap1", n, 4);
    do_txn(2, 1'b1, 3, 1'b1, -1, n);
    chk("t2_gap2", n, 4);
    do_txn(3, 1'b1, 3, 1'b1, -1, n);
    chk("t2_gap3", n, 4);
    lane_req = 4'b0000;
    chk("t2_lane_det", lane_det, 4'b1111);

    // Stray det_ack while not waiting is ignored
    det_ack = 1'b1;
    det_vld = 1'b0;
    tick();
    det_ack = 1'b0;
    chk("stray_ack_lane_ack", lane_ack, 0);
    chk("stray_ack_busy", busy, 0);
    repeat (3) tick();

    // T1: single lane, det_req high for 500 cycles before det_ack
    lane_req = 4'b0001;
    do_txn(0, 1'b1, T1_HOLD, 1'b1, -1, n);
    chk("t1_latency", n, 2);
    lane_req = 4'b0000;
    chk("t1_lane_det", lane_det, 4'b1111);

    // T4: lane 1 drops its request mid-WAIT; no ack, result discarded
    lane_req = 4'b0010;
    do_txn(1, 1'b0, 5, 1'b0, 2, n);
    chk("t4_lane_det", lane_det, 4'b1111);

    // T3: pointer now 2, lanes 0 and 1 requesting -> 0 then 1
    lane_req = 4'b0011;
    do_txn(0, 1'b0, 2, 1'b1, -1, n);
    chk("t3_gap_first", n, 4);
    lane_req[0] = 1'b0;
    do_txn(1, 1'b0, 2, 1'b1, -1, n);
    chk("t3_gap_second", n, 4);
    lane_req = 4'b0000;
    chk("t3_lane_det", lane_det, 4'b1100);

`ifdef RX_DET_ARB_TIMEOUT_EN
    // T5: no det_ack -> abort 17 cycles after ISSUE
    lane_req = 4'b0100;
    n = 0;
    while (det_req !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    chk("t5_det_req", det_req, 1);
    chk("t5_grant_id", grant_id, 2);
    k = 0;
    while (timeout !== 1'b1 && k < 40) begin
      tick();
      k++;
    end
    chk("t5_timeout_delay", k, 16);
    chk("t5_lane_ack", lane_ack, 4'b0100);
    chk("t5_lane_det", lane_det, 4'b1000);
    chk("t5_det_req_low", det_req, 0);
    tick();
    chk("t5_timeout_pulse", timeout, 0);
    lane_req = 4'b0000;
`else
    // Without the timeout option a long wait never aborts
    lane_req = 4'b0100;
    do_txn(2, 1'b0, 40, 1'b1, -1, n);
    lane_req = 4'b0000;
    chk("long_wait_lane_det", lane_det, 4'b1000);
`endif

    // T6: reset during WAIT, then service restarts from lane 0
    lane_req = 4'b1000;
    n = 0;
    while (det_req !== 1'b1 && n < 64) begin
      tick();
      n++;
    end
    chk("t6_det_req", det_req, 1);
    chk("t6_grant_id", grant_id, 3);
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("t6_det_req_drop", det_req, 0);
    chk("t6_busy", busy, 0);
    chk("t6_lane_ack", lane_ack, 0);
    chk("t6_lane_det", lane_det, 0);
    chk("t6_grant_id_rst", grant_id, 0);
    chk("t6_timeout", timeout, 0);
    rst      = 1'b1;
    lane_req = 4'b1001;
    do_txn(0, 1'b1, 2, 1'b1, -1, n);
    chk("t6_latency", n, 2);
    lane_req = 4'b0000;
    chk("t6_lane_det_after", lane_det, 4'b0001);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
